adaptive_frequency_regulator: RTL
=================================

Name: adaptive_frequency_regulator

Overview:
Parametrised successor of the single-channel PSI frequency regulator. Measures the high-time of the PSI phase-status pulse in clk cycles and compares it with setPeriod plus a programmable dead band. It then steps the divider value adjustedDiv up or down, saturating at the limits, and reports lock after repeated in-band pulses. The block sits between the phase comparator (PSI source) and the programmable clock divider that consumes adjustedDiv. Everything runs synchronously on clk; nothing is clocked on PSI.

Parameters:
DIV_W, 8, width of setPeriod, tolerance and adjustedDiv
CNT_W, 9, width of the duration counter (must be > DIV_W)
DIV_RESET, 8'h7F, adjustedDiv value after reset
DIV_MIN, 1, lower saturation limit for adjustedDiv
DIV_MAX, 255, upper saturation limit for adjustedDiv
STEP, 1, amount adjustedDiv changes per correction
SYNC_STAGES, 2, PSI synchroniser depth (0 = PSI already in the clk domain)
LOCK_COUNT, 4, consecutive in-band evaluations needed to assert locked

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
PSI  in  1  phase-status pulse; may be asynchronous to clk
setPeriod  in  DIV_W  target high-time in clk cycles
tolerance  in  DIV_W  dead band (plus or minus) around setPeriod
hold  in  1  1 = freeze adjustedDiv; measurement and flags continue
adjustedDiv  out  DIV_W  divider value sent to the clock divider
duration  out  CNT_W  high-time of the last completed pulse
inc  out  1  one-cycle pulse when adjustedDiv is incremented
dec  out  1  one-cycle pulse when adjustedDiv is decremented
eval_valid  out  1  one-cycle pulse when duration is updated
locked  out  1  regulator in band
overflow  out  1  sticky flag; the last pulse saturated the counter

Behaviour:
- Reset (rst=0, asynchronous) clears all state immediately:
  - adjustedDiv=DIV_RESET; duration, inc, dec, eval_valid, locked, overflow all 0.
  - Synchroniser flops and FSM go to WAIT_LOW.
  - A reset in mid-pulse discards that pulse.
- Signal path: psi_s is PSI after SYNC_STAGES flops; psi_d is psi_s delayed one cycle. rise = psi_s & ~psi_d; fall = ~psi_s & psi_d.
- FSM states: WAIT_LOW, ARMED, MEASURE, EVAL.
  - WAIT_LOW -> ARMED when psi_s=0. This prevents measuring a pulse that was already high when reset released.
  - ARMED -> MEASURE on rise; cnt<=1.
  - MEASURE, psi_s=1: cnt<=cnt+1, saturating at 2^CNT_W-1. On saturation ovf_int<=1.
  - MEASURE, fall: duration<=cnt; overflow<=ovf_int; go to EVAL. An N-cycle high pulse gives duration=N.
  - EVAL lasts one cycle and pulses eval_valid.
    - If a rise occurs in the EVAL cycle: cnt<=1, clear ovf_int, go straight to MEASURE.
    - Otherwise go to ARMED.
- Comparison in EVAL uses CNT_W+1-bit unsigned arithmetic. S = zero-extended setPeriod, T = zero-extended tolerance.
  - High: overflow or duration > S+T. Pulse inc; adjustedDiv<=min(adjustedDiv+STEP, DIV_MAX).
  - Low: duration+T < S. Pulse dec; adjustedDiv<=max(adjustedDiv-STEP, DIV_MIN).
  - Otherwise in band: lock counter increments, saturating at LOCK_COUNT.
- Saturation: if adjustedDiv is already at its limit, the value is unchanged but inc/dec still pulses.
- hold=1 during EVAL: adjustedDiv is unchanged; inc/dec still pulse (they are diagnostic).
- Lock:
  - locked=1 once the lock counter reaches LOCK_COUNT.
  - Any inc or dec clears the lock counter and deasserts locked in the same EVAL cycle.
  - Lock status changes only in EVAL.
- Timing: latency from the PSI falling edge to the inc/dec/eval_valid pulse is SYNC_STAGES+2 clk cycles. adjustedDiv updates on the same edge that asserts inc/dec.
- The comparison uses setPeriod and tolerance as sampled in the EVAL cycle.

Decomposition:
- Package freq_reg_pkg:
  - state enum (WAIT_LOW, ARMED, MEASURE, EVAL);
  - default parameter constants;
  - function sat_add_sub(value, step, min, max, dir).
- One sub-module, psi_edge_detect: parametrised SYNC_STAGES synchroniser plus delay flop; outputs psi_s, rise and fall.

Test Plan:
1. Reset, then 10 PSI pulses of 127 cycles high / 50 low, with setPeriod=127, tolerance=0 -> duration=127 each time; no inc/dec; locked=1 after the 4th eval_valid.
2. Pulses 140 cycles high, setPeriod=127, tolerance=5 -> inc on every eval; adjustedDiv 127->128->129. With tolerance=13 -> in band; no inc.
3. adjustedDiv driven down to DIV_MIN=1 by 110-cycle pulses, setPeriod=200 -> dec keeps pulsing; adjustedDiv stays 1. Symmetric test at DIV_MAX=255 with inc.
4. PSI held high for 600 cycles -> duration=511, overflow=1, inc pulses; the next normal pulse clears overflow.
5. PSI high at reset release -> first pulse ignored (no eval_valid). Assert rst in mid-MEASURE -> outputs return to reset values asynchronously.
6. hold=1 with 140-cycle pulses -> inc pulses, adjustedDiv constant. Back-to-back pulse (rise in the EVAL cycle) -> the second pulse is measured correctly.

Source files
------------

// File: rtl/freq_reg_pkg.sv
// Shared types, default parameter values and saturating step helper for the
// adaptive frequency regulator.
package freq_reg_pkg;

    typedef enum logic [1:0] {
        WAIT_LOW,
        ARMED,
        MEASURE,
        EVAL
    } state_t;

    localparam int DEF_DIV_W       = 8;
    localparam int DEF_CNT_W       = 9;
    localparam int DEF_DIV_RESET   = 8'h7F;
    localparam int DEF_DIV_MIN     = 1;
    localparam int DEF_DIV_MAX     = 255;
    localparam int DEF_STEP        = 1;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_LOCK_COUNT  = 4;

    // up=1 adds step clamped at hi, up=0 subtracts step clamped at lo.
    // The extra bit keeps value+step and lo+step from wrapping.
    function automatic logic [31:0] sat_add_sub(
        input logic [31:0] value,
        input logic [31:0] step,
        input logic [31:0] lo,
        input logic [31:0] hi,
        input logic        up
    );
        logic [32:0] wide;
        if (up) begin
            wide = {1'b0, value} + {1'b0, step};
            sat_add_sub = (wide > {1'b0, hi}) ? hi : wide[31:0];
        end else begin
            wide = {1'b0, lo} + {1'b0, step};
            sat_add_sub = ({1'b0, value} < wide) ? lo : (value - step);
        end
    endfunction

endpackage

// File: rtl/adaptive_frequency_regulator_if.sv
// Signal bundle between the PSI source / configuration side (master) and the
// regulator (slave).
interface adaptive_frequency_regulator_if
    import freq_reg_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int CNT_W = DEF_CNT_W
);
    logic             PSI;
    logic [DIV_W-1:0] setPeriod;
    logic [DIV_W-1:0] tolerance;
    logic             hold;
    logic [DIV_W-1:0] adjustedDiv;
    logic [CNT_W-1:0] duration;
    logic             inc;
    logic             dec;
    logic             eval_valid;
    logic             locked;
    logic             overflow;

    modport master (
        output PSI, setPeriod, tolerance, hold,
        input  adjustedDiv, duration, inc, dec, eval_valid, locked, overflow
    );

    modport slave (
        input  PSI, setPeriod, tolerance, hold,
        output adjustedDiv, duration, inc, dec, eval_valid, locked, overflow
    );
endinterface

// File: rtl/psi_edge_detect.sv
// PSI synchroniser plus one-cycle delay flop; derives psi_s, rise and fall.
// Latency: SYNC_STAGES cycles to psi_s, rise/fall combinational on psi_s/psi_d.
// Backpressure: none, free-running sampler.
module psi_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic psi,
    output logic psi_s,
    output logic rise,
    output logic fall
);

    logic psi_d;

    // Flops reset high so a pulse already in progress at reset release looks
    // like "still high" and is never mistaken for a fresh rising edge.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign psi_s = psi;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync_q <= '1;
                end else begin
                    sync_q[0] <= psi;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign psi_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psi_d <= 1'b1;
        end else begin
            psi_d <= psi_s;
        end
    end

    assign rise = psi_s & ~psi_d;
    assign fall = ~psi_s & psi_d;

endmodule

// File: rtl/adaptive_frequency_regulator.sv
// Measures PSI high-time and steps adjustedDiv toward setPeriod +/- tolerance.
// Latency: PSI fall to eval_valid/inc/dec is SYNC_STAGES+2 clk cycles.
// Backpressure: none, one evaluation per PSI pulse.
module adaptive_frequency_regulator
    import freq_reg_pkg::*;
#(
    parameter int DIV_W       = DEF_DIV_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DIV_RESET   = DEF_DIV_RESET,
    parameter int DIV_MIN     = DEF_DIV_MIN,
    parameter int DIV_MAX     = DEF_DIV_MAX,
    parameter int STEP        = DEF_STEP,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LOCK_COUNT  = DEF_LOCK_COUNT
) (
    input logic                           clk,
    input logic                           rst,
    adaptive_frequency_regulator_if.slave bus
);

    localparam int               LW       = $clog2(LOCK_COUNT + 1);
    localparam logic [LW-1:0]    LOCK_MAX = LW'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             ovf_int_q, ovf_int_nxt;
    logic [CNT_W-1:0] dur_q, dur_nxt;
    logic             ovf_q, ovf_nxt;
    logic [DIV_W-1:0] adj_q, adj_nxt;
    logic [LW-1:0]    lock_cnt_q, lock_cnt_nxt;
    logic             locked_q, locked_nxt;
    logic             inc_q, inc_nxt;
    logic             dec_q, dec_nxt;
    logic             ev_q, ev_nxt;

    logic psi_s, rise, fall;

    psi_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
        .clk   (clk),
        .rst   (rst),
        .psi   (bus.PSI),
        .psi_s (psi_s),
        .rise  (rise),
        .fall  (fall)
    );

    // One extra bit so S+T and duration+T cannot wrap.
    logic [CNT_W:0]   s_ext, t_ext, d_ext;
    logic             too_high, too_low;
    logic [DIV_W-1:0] adj_up, adj_dn;

    assign s_ext    = {{(CNT_W + 1 - DIV_W){1'b0}}, bus.setPeriod};
    assign t_ext    = {{(CNT_W + 1 - DIV_W){1'b0}}, bus.tolerance};
    assign d_ext    = {1'b0, dur_q};
    assign too_high = ovf_q || (d_ext > (s_ext + t_ext));
    assign too_low  = (d_ext + t_ext) < s_ext;

    assign adj_up = DIV_W'(sat_add_sub(32'(adj_q), 32'(STEP), 32'(DIV_MIN), 32'(DIV_MAX), 1'b1));
    assign adj_dn = DIV_W'(sat_add_sub(32'(adj_q), 32'(STEP), 32'(DIV_MIN), 32'(DIV_MAX), 1'b0));

    always_comb begin
        state_nxt    = state_q;
        cnt_nxt      = cnt_q;
        ovf_int_nxt  = ovf_int_q;
        dur_nxt      = dur_q;
        ovf_nxt      = ovf_q;
        adj_nxt      = adj_q;
        lock_cnt_nxt = lock_cnt_q;
        locked_nxt   = locked_q;
        inc_nxt      = 1'b0;
        dec_nxt      = 1'b0;
        ev_nxt       = 1'b0;

        case (state_q)
            WAIT_LOW: begin
                if (!psi_s) state_nxt = ARMED;
            end
            ARMED: begin
                if (rise) begin
                    state_nxt   = MEASURE;
                    cnt_nxt     = CNT_W'(1);
                    ovf_int_nxt = 1'b0;
                end
            end
            MEASURE: begin
                if (fall) begin
                    dur_nxt   = cnt_q;
                    ovf_nxt   = ovf_int_q;
                    state_nxt = EVAL;
                end else if (psi_s) begin
                    if (cnt_q == CNT_MAX) ovf_int_nxt = 1'b1;
                    else                  cnt_nxt     = cnt_q + 1'b1;
                end
            end
            EVAL: begin
                ev_nxt = 1'b1;
                if (too_high) begin
                    inc_nxt      = 1'b1;
                    lock_cnt_nxt = '0;
                    locked_nxt   = 1'b0;
                    if (!bus.hold) adj_nxt = adj_up;
                end else if (too_low) begin
                    dec_nxt      = 1'b1;
                    lock_cnt_nxt = '0;
                    locked_nxt   = 1'b0;
                    if (!bus.hold) adj_nxt = adj_dn;
                end else begin
                    if (lock_cnt_q != LOCK_MAX) lock_cnt_nxt = lock_cnt_q + 1'b1;
                    locked_nxt = (lock_cnt_nxt == LOCK_MAX);
                end
                // A pulse may start in this very cycle; catch it without re-arming.
                if (rise) begin
                    state_nxt   = MEASURE;
                    cnt_nxt     = CNT_W'(1);
                    ovf_int_nxt = 1'b0;
                end else begin
                    state_nxt = ARMED;
                end
            end
            default: state_nxt = WAIT_LOW;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= WAIT_LOW;
            cnt_q      <= '0;
            ovf_int_q  <= 1'b0;
            dur_q      <= '0;
            ovf_q      <= 1'b0;
            adj_q      <= DIV_W'(DIV_RESET);
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            ev_q       <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            ovf_int_q  <= ovf_int_nxt;
            dur_q      <= dur_nxt;
            ovf_q      <= ovf_nxt;
            adj_q      <= adj_nxt;
            lock_cnt_q <= lock_cnt_nxt;
            locked_q   <= locked_nxt;
            inc_q      <= inc_nxt;
            dec_q      <= dec_nxt;
            ev_q       <= ev_nxt;
        end
    end

    assign bus.adjustedDiv = adj_q;
    assign bus.duration    = dur_q;
    assign bus.inc         = inc_q;
    assign bus.dec         = dec_q;
    assign bus.eval_valid  = ev_q;
    assign bus.locked      = locked_q;
    assign bus.overflow    = ovf_q;

endmodule
